// File: rtl/fir_pcpi_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fir_acc_pkg
// Shared definitions for the FIR accelerator PCPI sequencer:
//   - custom-0 opcode / funct7 / funct3 encodings
//   - sequencer state enum
//   - counter width helper and instruction match helper
// No ports (package).
// -----------------------------------------------------------------------------
package fir_acc_pkg;

   localparam logic [6:0] FIR_OPCODE = 7'b0001011;
   localparam logic [6:0] FIR_FUNCT7 = 7'b0000001;

   localparam logic [2:0] F3_CFG    = 3'd0;
   localparam logic [2:0] F3_PUSH   = 3'd1;
   localparam logic [2:0] F3_RUN    = 3'd2;
   localparam logic [2:0] F3_STATUS = 3'd3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EXEC  = 3'd1,
      STAGE = 3'd2,
      ACK   = 3'd3,
      COOL  = 3'd4
   } seq_state_e;

   // Width of a counter that must hold values 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // True only for the four supported FIR instructions; any other funct3
   // is left unclaimed so the CPU raises an illegal-instruction trap.
   function automatic logic is_fir_insn(input logic [31:0] insn);
      return (insn[6:0] == FIR_OPCODE) &&
             (insn[31:25] == FIR_FUNCT7) &&
             (insn[14] == 1'b0);
   endfunction

endpackage

// File: rtl/fir_pcpi_sequencer_if.sv
// -----------------------------------------------------------------------------
// fir_pcpi_sequencer_if
// PicoRV32 PCPI bus bundle.
//   pcpi_valid / pcpi_insn / pcpi_rs1 / pcpi_rs2 : CPU -> coprocessor
//   pcpi_wr / pcpi_rd / pcpi_wait / pcpi_ready   : coprocessor -> CPU
// Modports: master (CPU side), slave (coprocessor side).
// -----------------------------------------------------------------------------
interface fir_pcpi_sequencer_if;

   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
   );

   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
   );

endinterface

// File: rtl/fir_pcpi_sequencer_timer.sv
// -----------------------------------------------------------------------------
// fir_stage_timer
// Walks the adder-tree stages in order, holding each stage enable for
// NUM_ADD_CLK cycles.
//   clk, reset    : clock, synchronous active-high reset
//   start_i       : begin a new pass at stage 0 (takes effect next cycle)
//   abort_i       : cancel the pass; also masks stage_en_o this cycle
//   stage_en_o    : one-hot stage enable, zero when idle
//   done_o        : high in the final cycle of the final stage
// -----------------------------------------------------------------------------
module fir_stage_timer
   import fir_acc_pkg::*;
#(
   parameter int NUM_ADDER_STAGES = 5,
   parameter int NUM_ADD_CLK      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start_i,
   input  logic                        abort_i,
   output logic [NUM_ADDER_STAGES-1:0] stage_en_o,
   output logic                        done_o
);

   localparam int STG_W = cnt_width(NUM_ADDER_STAGES);
   localparam int CYC_W = cnt_width(NUM_ADD_CLK);
   localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_ADDER_STAGES - 1);
   localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(NUM_ADD_CLK - 1);

   logic             active_q, active_d;
   logic [STG_W-1:0] stage_q, stage_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             last_cyc, last_stg;

   assign last_cyc = (cyc_q == LAST_CYC);
   assign last_stg = (stage_q == LAST_STG);
   assign done_o   = active_q && !abort_i && last_cyc && last_stg;

   always_comb begin
      active_d = active_q;
      stage_d  = stage_q;
      cyc_d    = cyc_q;
      if (start_i) begin
         active_d = 1'b1;
         stage_d  = '0;
         cyc_d    = '0;
      end else if (abort_i) begin
         active_d = 1'b0;
         stage_d  = '0;
         cyc_d    = '0;
      end else if (active_q) begin
         if (last_cyc) begin
            cyc_d = '0;
            if (last_stg) begin
               active_d = 1'b0;
               stage_d  = '0;
            end else begin
               stage_d = stage_q + 1'b1;
            end
         end else begin
            cyc_d = cyc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         stage_q  <= '0;
         cyc_q    <= '0;
      end else begin
         active_q <= active_d;
         stage_q  <= stage_d;
         cyc_q    <= cyc_d;
      end
   end

   // One-hot decode of the stage index; an abort blanks the enable at once.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_ADDER_STAGES; gi++) begin : g_stage_en
         assign stage_en_o[gi] = active_q && !abort_i && (stage_q == STG_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/fir_pcpi_sequencer.sv
// -----------------------------------------------------------------------------
// fir_pcpi_sequencer
// PCPI-side controller for the FIR accelerator. Decodes custom-0 FIR
// instructions, strobes coefficient writes / sample shifts into the datapath,
// sequences the adder tree stage by stage and returns results to the CPU.
//   clk, reset       : clock, synchronous active-high reset
//   pcpi             : PCPI bus (slave side)
//   coef_we/addr/wdata : coefficient write port, one-cycle strobe
//   sample_shift/data  : sample shift port, one-cycle strobe
//   stage_en         : one-hot adder-tree stage enable
//   result_in        : final adder-tree sum
//   busy             : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module fir_pcpi_sequencer
   import fir_acc_pkg::*;
#(
   parameter int K                 = 128,
   parameter int N                 = 7,
   parameter int WIDTH_COEFFICIENT = 32,
   parameter int NUM_ADDER_STAGES  = 5,
   parameter int NUM_ADD_CLK       = 4,
   parameter int COEF_ADDR_W       = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   fir_pcpi_sequencer_if.slave           pcpi,
   output logic                          coef_we,
   output logic [COEF_ADDR_W-1:0]        coef_addr,
   output logic [WIDTH_COEFFICIENT-1:0]  coef_wdata,
   output logic                          sample_shift,
   output logic [N-1:0]                  sample_data,
   output logic [NUM_ADDER_STAGES-1:0]   stage_en,
   input  logic [31:0]                   result_in,
   output logic                          busy
);

   seq_state_e                   state_q, state_d;
   logic [2:0]                   funct3_q;
   logic [COEF_ADDR_W-1:0]       addr_q;
   logic [WIDTH_COEFFICIENT-1:0] wdata_q;
   logic [N-1:0]                 sample_q;
   logic [15:0]                  push_count_q, push_count_d;

   logic insn_match;
   logic accept;
   logic timer_start;
   logic timer_abort;
   logic timer_done;

   assign insn_match = is_fir_insn(pcpi.pcpi_insn);
   assign accept     = (state_q == IDLE) && pcpi.pcpi_valid && insn_match;
   assign busy       = (state_q != IDLE);

   // Only the low operand bits and K are informational here; folding them
   // into one unused net keeps the full bus visible without extra logic.
   logic unused_ok;
   assign unused_ok = &{1'b0, pcpi.pcpi_insn, pcpi.pcpi_rs1, pcpi.pcpi_rs2, (K > 0)};

   fir_stage_timer #(
      .NUM_ADDER_STAGES (NUM_ADDER_STAGES),
      .NUM_ADD_CLK      (NUM_ADD_CLK)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .start_i    (timer_start),
      .abort_i    (timer_abort),
      .stage_en_o (stage_en),
      .done_o     (timer_done)
   );

   always_comb begin
      state_d         = state_q;
      push_count_d    = push_count_q;
      timer_start     = 1'b0;
      timer_abort     = 1'b0;
      pcpi.pcpi_wait  = 1'b0;
      pcpi.pcpi_ready = 1'b0;
      pcpi.pcpi_wr    = 1'b0;
      pcpi.pcpi_rd    = '0;
      coef_we         = 1'b0;
      coef_addr       = '0;
      coef_wdata      = '0;
      sample_shift    = 1'b0;
      sample_data     = '0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (pcpi.pcpi_insn[14:12] == F3_RUN) begin
                  state_d     = STAGE;
                  timer_start = 1'b1;
               end else begin
                  state_d = EXEC;
               end
            end
         end

         EXEC: begin
            // The CPU withdrawing the instruction cancels it before any
            // side effect reaches the datapath.
            if (!pcpi.pcpi_valid) begin
               state_d = IDLE;
            end else begin
               state_d        = ACK;
               pcpi.pcpi_wait = 1'b1;
               if (funct3_q == F3_CFG) begin
                  coef_we    = 1'b1;
                  coef_addr  = addr_q;
                  coef_wdata = wdata_q;
               end
               if (funct3_q == F3_PUSH) begin
                  sample_shift = 1'b1;
                  sample_data  = sample_q;
                  if (push_count_q != 16'hFFFF) begin
                     push_count_d = push_count_q + 16'd1;
                  end
               end
            end
         end

         STAGE: begin
            if (!pcpi.pcpi_valid) begin
               state_d     = IDLE;
               timer_abort = 1'b1;
            end else begin
               pcpi.pcpi_wait = 1'b1;
               if (timer_done) begin
                  state_d = ACK;
               end
            end
         end

         ACK: begin
            state_d         = COOL;
            pcpi.pcpi_wait  = 1'b1;
            pcpi.pcpi_ready = 1'b1;
            if (funct3_q == F3_RUN) begin
               // The tree has settled by now: this is the cycle after the
               // last stage enable, so the sum is taken straight through.
               pcpi.pcpi_wr = 1'b1;
               pcpi.pcpi_rd = result_in;
               push_count_d = '0;
            end else if (funct3_q == F3_STATUS) begin
               pcpi.pcpi_wr = 1'b1;
               pcpi.pcpi_rd = {16'b0, push_count_q};
            end
         end

         COOL: begin
            // pcpi_valid may still show the retiring instruction; skip it.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         funct3_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         sample_q     <= '0;
         push_count_q <= '0;
      end else begin
         state_q      <= state_d;
         push_count_q <= push_count_d;
         if (accept) begin
            funct3_q <= pcpi.pcpi_insn[14:12];
            addr_q   <= pcpi.pcpi_rs1[COEF_ADDR_W-1:0];
            wdata_q  <= pcpi.pcpi_rs2[WIDTH_COEFFICIENT-1:0];
            sample_q <= pcpi.pcpi_rs1[N-1:0];
         end
      end
   end

endmodule

// File: tb/tb_fir_pcpi_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_pcpi_sequencer
// Self-checking bench for fir_pcpi_sequencer: directed scenarios followed by
// randomized instruction traffic checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_fir_pcpi_sequencer;
   import fir_acc_pkg::*;

   localparam int S       = 5;
   localparam int C       = 4;
   localparam int NB      = 7;
   localparam int RUN_LAT = S * C + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        coef_we;
   logic [15:0] coef_addr;
   logic [31:0] coef_wdata;
   logic        sample_shift;
   logic [NB-1:0] sample_data;
   logic [S-1:0]  stage_en;
   logic [31:0] result_in;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned model_count = 0;

   fir_pcpi_sequencer_if pif();

   fir_pcpi_sequencer #(
      .K(128), .N(NB), .WIDTH_COEFFICIENT(32),
      .NUM_ADDER_STAGES(S), .NUM_ADD_CLK(C), .COEF_ADDR_W(16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pcpi         (pif),
      .coef_we      (coef_we),
      .coef_addr    (coef_addr),
      .coef_wdata   (coef_wdata),
      .sample_shift (sample_shift),
      .sample_data  (sample_data),
      .stage_en     (stage_en),
      .result_in    (result_in),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [6:0] opc);
      return {f7, 5'd3, 5'd2, f3, 5'd1, opc};
   endfunction

   // Drive one instruction from an idle sequencer and compare what the
   // datapath and CPU see against what the instruction should do.
   task automatic run_txn(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] res);
      int lat, ready_cyc, n_we, n_sh, st_err, wt_err;
      logic        wr_got, exp_wr;
      logic [31:0] rd_got, exp_rd, addr_got, data_got, samp_got;
      logic [S-1:0] exp_st;
      lat       = (f3 == F3_RUN) ? RUN_LAT : 2;
      exp_wr    = (f3 == F3_RUN) || (f3 == F3_STATUS);
      exp_rd    = (f3 == F3_RUN) ? res : (f3 == F3_STATUS) ? {16'b0, model_count[15:0]} : 32'd0;
      ready_cyc = -1;
      n_we = 0; n_sh = 0; st_err = 0; wt_err = 0;
      wr_got = 1'b0; rd_got = '0; addr_got = '0; data_got = '0; samp_got = '0;

      result_in      = res;
      pif.pcpi_insn  = mk_insn(f3, FIR_FUNCT7, FIR_OPCODE);
      pif.pcpi_rs1   = rs1;
      pif.pcpi_rs2   = rs2;
      pif.pcpi_valid = 1'b1;
      for (int c = 1; c <= RUN_LAT + 5 && ready_cyc < 0; c++) begin
         @(negedge clk);
         exp_st = (f3 == F3_RUN && c <= S * C) ? S'(1 << ((c - 1) / C)) : '0;
         if (stage_en !== exp_st) st_err++;
         if (pif.pcpi_wait !== (c <= lat)) wt_err++;
         if (coef_we === 1'b1) begin
            n_we++; addr_got = 32'(coef_addr); data_got = coef_wdata;
         end
         if (sample_shift === 1'b1) begin
            n_sh++; samp_got = 32'(sample_data);
         end
         if (pif.pcpi_ready === 1'b1) begin
            ready_cyc = c; wr_got = pif.pcpi_wr; rd_got = pif.pcpi_rd;
         end else if (pif.pcpi_wr !== 1'b0 || pif.pcpi_rd !== 32'd0) begin
            wt_err++;
         end
      end
      pif.pcpi_valid = 1'b0;
      @(negedge clk);
      if (pif.pcpi_wait !== 1'b0 || pif.pcpi_ready !== 1'b0 || stage_en !== '0) wt_err++;
      @(negedge clk);

      chk({tag, ".ready_cycle"}, 64'(ready_cyc), 64'(lat));
      chk({tag, ".wr"}, 64'(wr_got), 64'(exp_wr));
      chk({tag, ".rd"}, 64'(rd_got), 64'(exp_rd));
      chk({tag, ".coef_we_count"}, 64'(n_we), (f3 == F3_CFG) ? 64'd1 : 64'd0);
      chk({tag, ".shift_count"}, 64'(n_sh), (f3 == F3_PUSH) ? 64'd1 : 64'd0);
      if (f3 == F3_CFG) begin
         chk({tag, ".coef_addr"}, 64'(addr_got), 64'(rs1[15:0]));
         chk({tag, ".coef_wdata"}, 64'(data_got), 64'(rs2));
      end
      if (f3 == F3_PUSH) chk({tag, ".sample_data"}, 64'(samp_got), 64'(rs1[NB-1:0]));
      chk({tag, ".stage_en_seq_errs"}, 64'(st_err), 64'd0);
      chk({tag, ".wait_wr_errs"}, 64'(wt_err), 64'd0);
      chk({tag, ".busy_after"}, 64'(busy), 64'd0);

      if (f3 == F3_PUSH && model_count < 32'hFFFF) model_count++;
      if (f3 == F3_RUN) model_count = 0;
      $display("[TB] txn %s f3=%0d rs1=%08h rs2=%08h ready@%0d wr=%0d rd=%08h", tag, f3, rs1,
               rs2, ready_cyc, wr_got, rd_got);
   endtask

   // Offer an instruction that must not be claimed.
   task automatic no_claim(input string tag, input logic [31:0] insn);
      int hits;
      hits           = 0;
      pif.pcpi_insn  = insn;
      pif.pcpi_rs1   = $urandom;
      pif.pcpi_rs2   = $urandom;
      pif.pcpi_valid = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (pif.pcpi_wait !== 1'b0 || pif.pcpi_ready !== 1'b0 || busy !== 1'b0) hits++;
      end
      pif.pcpi_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".claimed_cycles"}, 64'(hits), 64'd0);
      $display("[TB] txn %s insn=%08h claimed_cycles=%0d", tag, insn, hits);
   endtask

   // Withdraw pcpi_valid at cycle drop_c of the instruction.
   task automatic abort_txn(input string tag, input logic [2:0] f3, input int drop_c);
      int readies, strobes;
      readies = 0; strobes = 0;
      pif.pcpi_insn  = mk_insn(f3, FIR_FUNCT7, FIR_OPCODE);
      pif.pcpi_rs1   = 32'h0000_0011;
      pif.pcpi_rs2   = 32'h1234_5678;
      pif.pcpi_valid = 1'b1;
      for (int c = 1; c < drop_c; c++) @(negedge clk);
      @(negedge clk);
      pif.pcpi_valid = 1'b0;
      #1;
      if (coef_we !== 1'b0 || sample_shift !== 1'b0 || stage_en !== '0) strobes++;
      for (int c = 0; c < RUN_LAT + 3; c++) begin
         @(negedge clk);
         if (pif.pcpi_ready !== 1'b0 || coef_we !== 1'b0 || sample_shift !== 1'b0 ||
             stage_en !== '0) readies++;
      end
      chk({tag, ".strobe_at_abort"}, 64'(strobes), 64'd0);
      chk({tag, ".activity_after_abort"}, 64'(readies), 64'd0);
      chk({tag, ".busy_after"}, 64'(busy), 64'd0);
      $display("[TB] txn %s f3=%0d dropped@%0d", tag, f3, drop_c);
   endtask

   initial begin
      int r1_c, r2_c, wt_err;
      logic [2:0]  f3;
      logic [31:0] snap;

      reset          = 1'b1;
      pif.pcpi_valid = 1'b0;
      pif.pcpi_insn  = '0;
      pif.pcpi_rs1   = '0;
      pif.pcpi_rs2   = '0;
      result_in      = '0;
      repeat (3) @(negedge clk);
      chk("reset.outputs",
          64'({pif.pcpi_wait, pif.pcpi_ready, pif.pcpi_wr, coef_we, sample_shift, busy}), 64'd0);
      chk("reset.rd_stage", 64'({pif.pcpi_rd, stage_en}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed scenarios
      run_txn("cfg5", F3_CFG, 32'd5, 32'hDEADBEEF, 32'h0);
      for (int i = 0; i < 3; i++) run_txn("push55", F3_PUSH, 32'h0000_0055, $urandom, 32'h0);
      run_txn("status3", F3_STATUS, $urandom, $urandom, 32'h0);
      run_txn("run1234", F3_RUN, $urandom, $urandom, 32'h0000_1234);
      run_txn("status0", F3_STATUS, $urandom, $urandom, 32'h0);
      run_txn("run_count0", F3_RUN, $urandom, $urandom, 32'hCAFE_0001);

      no_claim("funct3_5", mk_insn(3'd5, FIR_FUNCT7, FIR_OPCODE));
      no_claim("opcode_op", mk_insn(F3_CFG, FIR_FUNCT7, 7'b0110011));
      no_claim("funct7_bad", mk_insn(F3_STATUS, 7'b0000000, FIR_OPCODE));

      run_txn("push_pre_abort", F3_PUSH, 32'h0000_0023, $urandom, 32'h0);
      abort_txn("abort_push", F3_PUSH, 1);
      abort_txn("abort_cfg", F3_CFG, 1);
      abort_txn("abort_run", F3_RUN, 5);
      run_txn("status_after_abort", F3_STATUS, $urandom, $urandom, 32'h0);

      // Reset in the middle of a RUN
      pif.pcpi_insn  = mk_insn(F3_RUN, FIR_FUNCT7, FIR_OPCODE);
      result_in      = 32'h5555_AAAA;
      pif.pcpi_valid = 1'b1;
      for (int c = 1; c <= 10; c++) @(negedge clk);
      reset          = 1'b1;
      pif.pcpi_valid = 1'b0;
      @(negedge clk);
      chk("midrun_reset.outputs",
          64'({pif.pcpi_wait, pif.pcpi_ready, pif.pcpi_wr, coef_we, sample_shift, busy, stage_en}),
          64'd0);
      chk("midrun_reset.rd", 64'(pif.pcpi_rd), 64'd0);
      reset       = 1'b0;
      model_count = 0;
      r1_c = 0;
      for (int c = 0; c < RUN_LAT; c++) begin
         @(negedge clk);
         if (pif.pcpi_ready !== 1'b0) r1_c++;
      end
      chk("midrun_reset.no_ready", 64'(r1_c), 64'd0);
      $display("[TB] txn midrun_reset late_ready_cycles=%0d", r1_c);
      run_txn("cfg_after_reset", F3_CFG, 32'h0000_ABCD, 32'h0BAD_F00D, 32'h0);
      run_txn("status_after_reset", F3_STATUS, $urandom, $urandom, 32'h0);

      // Back-to-back: valid held through ready, re-accept only after COOL
      pif.pcpi_insn  = mk_insn(F3_STATUS, FIR_FUNCT7, FIR_OPCODE);
      pif.pcpi_valid = 1'b1;
      r1_c = -1; r2_c = -1; wt_err = 0; snap = '0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (pif.pcpi_wait !== (c <= 2 || c >= 5)) wt_err++;
         if (pif.pcpi_ready === 1'b1) begin
            if (r1_c < 0) r1_c = c;
            else if (r2_c < 0) begin
               r2_c = c; snap = pif.pcpi_rd;
            end
         end
      end
      pif.pcpi_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("b2b.first_ready", 64'(r1_c), 64'd2);
      chk("b2b.second_ready", 64'(r2_c), 64'd6);
      chk("b2b.second_rd", 64'(snap), 64'(model_count));
      chk("b2b.wait_errs", 64'(wt_err), 64'd0);
      $display("[TB] txn b2b ready@%0d and @%0d", r1_c, r2_c);

      // Randomized traffic against the model
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 3));
         run_txn($sformatf("rnd%0d", i), f3, $urandom, $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
